// File: rtl/lc3_isdu_ctrl.sv
// LC-3 instruction sequencing and decode unit.
// Moore state machine that fetches, decodes and executes ADD/AND/NOT/BR/JMP/
// JSR/JSRR/LDR/STR/PAUSE by driving every load, gate and select of the datapath
// plus the active-low SRAM strobes. Memory states are held for a fixed number of
// cycles so slow SRAM works without a ready handshake.

module lc3_isdu_ctrl #(
   parameter int MEM_RD_CYCLES = 3,
   parameter int MEM_WR_CYCLES = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       IR_11,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       LD_PC,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] PCMUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       ADDR1MUX,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       SR2MUX,
   output logic       MIO_EN,
   output logic       Mem_OE_n,
   output logic       Mem_WE_n
);

   localparam int MAX_CYC = (MEM_RD_CYCLES > MEM_WR_CYCLES) ? MEM_RD_CYCLES : MEM_WR_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(MEM_RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(MEM_WR_CYCLES - 1);

   typedef enum logic [4:0] {
      HALTED, S18, S33, S35, S32,
      S01, S05, S09, S00, S22,
      S12, S04, S21, S20, S06,
      S07, S25, S27, S23, S16,
      P1, P2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic             ir5_q;
   logic             mem_state;

   assign mem_state = (state == S33) || (state == S25) || (state == S16);

   // State register, memory wait counter and a registered copy of IR[5] so that
   // SR2MUX stays a function of registered state only (captured once IR is valid).
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state    <= HALTED;
         wait_cnt <= '0;
         ir5_q    <= 1'b0;
      end else begin
         state <= next_state;
         if ((next_state != state) || !mem_state)
            wait_cnt <= '0;
         else
            wait_cnt <= wait_cnt + CNT_W'(1);
         if (state == S32)
            ir5_q <= IR_5;
      end
   end

   // Next-state selection: fetch, opcode dispatch, execute and pause handshake.
   always_comb begin
      next_state = state;
      unique case (state)
         HALTED: if (Run) next_state = S18;
         S18:    next_state = S33;
         S33:    if (wait_cnt == RD_LAST) next_state = S35;
         S35:    next_state = S32;
         S32: begin
            unique case (Opcode)
               4'b0001: next_state = S01;
               4'b0101: next_state = S05;
               4'b1001: next_state = S09;
               4'b0000: next_state = S00;
               4'b1100: next_state = S12;
               4'b0100: next_state = S04;
               4'b0110: next_state = S06;
               4'b0111: next_state = S07;
               4'b1101: next_state = P1;
               default: next_state = S18;
            endcase
         end
         S01, S05, S09: next_state = S18;
         S00:    next_state = BEN ? S22 : S18;
         S22:    next_state = S18;
         S12:    next_state = S18;
         S04:    next_state = IR_11 ? S21 : S20;
         S21, S20: next_state = S18;
         S06:    next_state = S25;
         S25:    if (wait_cnt == RD_LAST) next_state = S27;
         S27:    next_state = S18;
         S07:    next_state = S23;
         S23:    next_state = S16;
         S16:    if (wait_cnt == WR_LAST) next_state = S18;
         P1:     if (Continue) next_state = P2;
         P2:     if (!Continue) next_state = S18;
         default: next_state = HALTED;
      endcase
   end

   // Datapath control decode: everything idle by default, each state asserts only its own controls.
   always_comb begin
      LD_MAR     = 1'b0;
      LD_MDR     = 1'b0;
      LD_IR      = 1'b0;
      LD_BEN     = 1'b0;
      LD_CC      = 1'b0;
      LD_REG     = 1'b0;
      LD_PC      = 1'b0;
      LD_LED     = 1'b0;
      GatePC     = 1'b0;
      GateMDR    = 1'b0;
      GateALU    = 1'b0;
      GateMARMUX = 1'b0;
      PCMUX      = 2'b00;
      ADDR2MUX   = 2'b00;
      ALUK       = 2'b00;
      ADDR1MUX   = 1'b0;
      DRMUX      = 1'b0;
      SR1MUX     = 1'b0;
      SR2MUX     = 1'b0;
      MIO_EN     = 1'b0;
      Mem_OE_n   = 1'b1;
      Mem_WE_n   = 1'b1;
      unique case (state)
         S18: begin
            GatePC = 1'b1;
            LD_MAR = 1'b1;
            PCMUX  = 2'b00;
            LD_PC  = 1'b1;
         end
         S33, S25: begin
            MIO_EN   = 1'b1;
            Mem_OE_n = 1'b0;
            LD_MDR   = 1'b1;
         end
         S35: begin
            GateMDR = 1'b1;
            LD_IR   = 1'b1;
         end
         S32: LD_BEN = 1'b1;
         S01, S05, S09: begin
            SR1MUX  = 1'b0;
            SR2MUX  = ir5_q;
            ALUK    = (state == S01) ? 2'b00 : ((state == S05) ? 2'b01 : 2'b10);
            GateALU = 1'b1;
            DRMUX   = 1'b0;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
         end
         S22: begin
            ADDR1MUX = 1'b1;
            ADDR2MUX = 2'b10;
            PCMUX    = 2'b01;
            LD_PC    = 1'b1;
         end
         S12, S20: begin
            SR1MUX   = 1'b0;
            ADDR1MUX = 1'b0;
            ADDR2MUX = 2'b00;
            PCMUX    = 2'b01;
            LD_PC    = 1'b1;
         end
         S04: begin
            GatePC = 1'b1;
            DRMUX  = 1'b1;
            LD_REG = 1'b1;
         end
         S21: begin
            ADDR1MUX = 1'b1;
            ADDR2MUX = 2'b11;
            PCMUX    = 2'b01;
            LD_PC    = 1'b1;
         end
         S06, S07: begin
            SR1MUX     = 1'b0;
            ADDR1MUX   = 1'b0;
            ADDR2MUX   = 2'b01;
            GateMARMUX = 1'b1;
            LD_MAR     = 1'b1;
         end
         S27: begin
            GateMDR = 1'b1;
            DRMUX   = 1'b0;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
         end
         S23: begin
            SR1MUX  = 1'b1;
            ALUK    = 2'b11;
            GateALU = 1'b1;
            MIO_EN  = 1'b0;
            LD_MDR  = 1'b1;
         end
         S16: begin
            Mem_WE_n = 1'b0;
            MIO_EN   = 1'b0;
         end
         P1: LD_LED = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lc3_isdu_ctrl.sv
// Testbench for lc3_isdu_ctrl: cycle-by-cycle table of inputs and expected
// control words for every instruction class, followed by hand-written pause
// and reset-during-write sequences.

module tb_lc3_isdu_ctrl;

   localparam int RD = 3;
   localparam int WR = 2;

   typedef struct packed {
      logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
      logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
      logic [1:0] pcmux, addr2mux, aluk;
      logic       addr1mux, drmux, sr1mux, sr2mux, mio_en, oe_n, we_n;
   } out_t;

   typedef struct {
      logic [47:0] tag;
      logic        rst, run, cont, ben, ir5, ir11;
      logic [3:0]  op;
      out_t        exp;
   } vec_t;

   logic       Clk = 1'b0;
   logic       Reset, Run, Continue, IR_5, IR_11, BEN;
   logic [3:0] Opcode;
   logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
   logic       GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   logic       ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN, Mem_OE_n, Mem_WE_n;
   out_t       act;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   logic live = 1'b0;
   logic [3:0] cur_op;
   logic cur_ir5, cur_ir11, cur_ben;

   // Free-running 10 ns clock.
   always #5 Clk = ~Clk;

   lc3_isdu_ctrl #(.MEM_RD_CYCLES(RD), .MEM_WR_CYCLES(WR)) dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
      .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
      .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
      .MIO_EN(MIO_EN), .Mem_OE_n(Mem_OE_n), .Mem_WE_n(Mem_WE_n)
   );

   // Collect the DUT outputs into one comparable control word.
   always_comb begin
      act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
             GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
             ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN, Mem_OE_n, Mem_WE_n};
   end

   function automatic out_t o_dflt();
      out_t o;
      o      = '0;
      o.oe_n = 1'b1;
      o.we_n = 1'b1;
      return o;
   endfunction

   function automatic out_t o_s18();
      out_t o = o_dflt();
      o.gate_pc = 1'b1; o.ld_mar = 1'b1; o.ld_pc = 1'b1;
      return o;
   endfunction

   function automatic out_t o_rd();
      out_t o = o_dflt();
      o.mio_en = 1'b1; o.oe_n = 1'b0; o.ld_mdr = 1'b1;
      return o;
   endfunction

   function automatic out_t o_s35();
      out_t o = o_dflt();
      o.gate_mdr = 1'b1; o.ld_ir = 1'b1;
      return o;
   endfunction

   function automatic out_t o_s32();
      out_t o = o_dflt();
      o.ld_ben = 1'b1;
      return o;
   endfunction

   function automatic out_t o_alu(input logic [1:0] k, input logic imm);
      out_t o = o_dflt();
      o.aluk = k; o.sr2mux = imm; o.gate_alu = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
      return o;
   endfunction

   function automatic out_t o_pcadd(input logic a1, input logic [1:0] a2);
      out_t o = o_dflt();
      o.addr1mux = a1; o.addr2mux = a2; o.pcmux = 2'b01; o.ld_pc = 1'b1;
      return o;
   endfunction

   function automatic out_t o_s04();
      out_t o = o_dflt();
      o.gate_pc = 1'b1; o.drmux = 1'b1; o.ld_reg = 1'b1;
      return o;
   endfunction

   function automatic out_t o_marea();
      out_t o = o_dflt();
      o.addr2mux = 2'b01; o.gate_marmux = 1'b1; o.ld_mar = 1'b1;
      return o;
   endfunction

   function automatic out_t o_s27();
      out_t o = o_dflt();
      o.gate_mdr = 1'b1; o.ld_reg = 1'b1; o.ld_cc = 1'b1;
      return o;
   endfunction

   function automatic out_t o_s23();
      out_t o = o_dflt();
      o.sr1mux = 1'b1; o.aluk = 2'b11; o.gate_alu = 1'b1; o.ld_mdr = 1'b1;
      return o;
   endfunction

   function automatic out_t o_s16();
      out_t o = o_dflt();
      o.we_n = 1'b0;
      return o;
   endfunction

   function automatic out_t o_p1();
      out_t o = o_dflt();
      o.ld_led = 1'b1;
      return o;
   endfunction

   // Drive one vector's inputs, let one rising edge pass, then settle before sampling.
   task automatic applyStimulus(input vec_t v);
      Reset    = v.rst;
      Run      = v.run;
      Continue = v.cont;
      BEN      = v.ben;
      IR_5     = v.ir5;
      IR_11    = v.ir11;
      Opcode   = v.op;
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      checks++;
      if (act !== v.exp) begin
         errors++;
         $display("[TB] FAIL step %0d %s: got %07h expected %07h", idx, v.tag, act, v.exp);
      end
   endtask

   // Either queue a step for the table or run and check it immediately.
   task automatic emit(input logic [47:0] tag, input logic rst, input logic run,
                       input logic cont, input out_t exp);
      vec_t v;
      v.tag = tag; v.rst = rst; v.run = run; v.cont = cont;
      v.ben = cur_ben; v.ir5 = cur_ir5; v.ir11 = cur_ir11; v.op = cur_op;
      v.exp = exp;
      if (live) begin
         applyStimulus(v);
         checkOutput(v, checks);
      end else begin
         vecs.push_back(v);
      end
   endtask

   task automatic fetch(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
      cur_op = op; cur_ir5 = ir5; cur_ir11 = ir11; cur_ben = ben;
      for (int i = 0; i < RD; i++) emit("S33", 1'b1, 1'b0, 1'b0, o_rd());
      emit("S35", 1'b1, 1'b0, 1'b0, o_s35());
      emit("S32", 1'b1, 1'b0, 1'b0, o_s32());
   endtask

   initial begin
      Reset = 1'b0; Run = 1'b1; Continue = 1'b0; BEN = 1'b0;
      IR_5 = 1'b0; IR_11 = 1'b0; Opcode = 4'b0000;
      cur_op = 4'b0001; cur_ir5 = 1'b1; cur_ir11 = 1'b0; cur_ben = 1'b0;

      // Reset held with Run high, then release into the first fetch.
      emit("HALT", 1'b0, 1'b1, 1'b0, o_dflt());
      emit("HALT", 1'b0, 1'b1, 1'b0, o_dflt());
      emit("S18", 1'b1, 1'b1, 1'b0, o_s18());
      // ADD immediate.
      fetch(4'b0001, 1'b1, 1'b0, 1'b0);
      emit("S01", 1'b1, 1'b0, 1'b0, o_alu(2'b00, 1'b1));
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());
      // BR not taken, then taken.
      fetch(4'b0000, 1'b0, 1'b0, 1'b0);
      emit("S00", 1'b1, 1'b0, 1'b0, o_dflt());
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());
      fetch(4'b0000, 1'b0, 1'b0, 1'b1);
      emit("S00", 1'b1, 1'b0, 1'b0, o_dflt());
      emit("S22", 1'b1, 1'b0, 1'b0, o_pcadd(1'b1, 2'b10));
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());
      // STR with the full write hold.
      fetch(4'b0111, 1'b0, 1'b0, 1'b0);
      emit("S07", 1'b1, 1'b0, 1'b0, o_marea());
      emit("S23", 1'b1, 1'b0, 1'b0, o_s23());
      for (int i = 0; i < WR; i++) emit("S16", 1'b1, 1'b0, 1'b0, o_s16());
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());
      // LDR with the full read hold.
      fetch(4'b0110, 1'b0, 1'b0, 1'b0);
      emit("S06", 1'b1, 1'b0, 1'b0, o_marea());
      for (int i = 0; i < RD; i++) emit("S25", 1'b1, 1'b0, 1'b0, o_rd());
      emit("S27", 1'b1, 1'b0, 1'b0, o_s27());
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());
      // JSR then JSRR.
      fetch(4'b0100, 1'b0, 1'b1, 1'b0);
      emit("S04", 1'b1, 1'b0, 1'b0, o_s04());
      emit("S21", 1'b1, 1'b0, 1'b0, o_pcadd(1'b1, 2'b11));
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());
      fetch(4'b0100, 1'b0, 1'b0, 1'b0);
      emit("S04", 1'b1, 1'b0, 1'b0, o_s04());
      emit("S20", 1'b1, 1'b0, 1'b0, o_pcadd(1'b0, 2'b00));
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());
      // JMP, AND register, NOT, and an unused opcode as NOP.
      fetch(4'b1100, 1'b0, 1'b0, 1'b0);
      emit("S12", 1'b1, 1'b0, 1'b0, o_pcadd(1'b0, 2'b00));
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());
      fetch(4'b0101, 1'b0, 1'b0, 1'b0);
      emit("S05", 1'b1, 1'b0, 1'b0, o_alu(2'b01, 1'b0));
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());
      fetch(4'b1001, 1'b1, 1'b0, 1'b0);
      emit("S09", 1'b1, 1'b0, 1'b0, o_alu(2'b10, 1'b1));
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());
      fetch(4'b1111, 1'b0, 1'b0, 1'b0);
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
      end

      // Pause: LED load held, one instruction per Continue press.
      live = 1'b1;
      fetch(4'b1101, 1'b0, 1'b0, 1'b0);
      emit("P1", 1'b1, 1'b0, 1'b0, o_p1());
      for (int i = 0; i < 10; i++) emit("P1", 1'b1, 1'b0, 1'b0, o_p1());
      emit("P2", 1'b1, 1'b0, 1'b1, o_dflt());
      emit("P2", 1'b1, 1'b0, 1'b1, o_dflt());
      emit("P2", 1'b1, 1'b0, 1'b1, o_dflt());
      emit("S18", 1'b1, 1'b0, 1'b0, o_s18());

      // Reset during the first write cycle cuts the write short and halts.
      fetch(4'b0111, 1'b0, 1'b0, 1'b0);
      emit("S07", 1'b1, 1'b0, 1'b0, o_marea());
      emit("S23", 1'b1, 1'b0, 1'b0, o_s23());
      emit("S16", 1'b1, 1'b0, 1'b0, o_s16());
      emit("HALT", 1'b0, 1'b0, 1'b0, o_dflt());
      for (int i = 0; i < 3; i++) emit("HALT", 1'b1, 1'b0, 1'b0, o_dflt());
      emit("S18", 1'b1, 1'b1, 1'b0, o_s18());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
